// File: rtl/synchronous_fifo_reader_if.sv
// rtl/synchronous_fifo_reader_if.sv - output stream bundle of the FIFO read-side controller
// The reader drives the master side; the downstream consumer uses the slave side.
interface synchronous_fifo_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/synchronous_fifo_reader.sv
// rtl/synchronous_fifo_reader.sv - read-side controller for the synchronous FIFO
// Registered poll, 2-slot output buffer, valid/ready stream out, transfer counter.
module synchronous_fifo_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       fifo_head,
   input  logic                        fifo_empty,
   output logic                        fifo_poll,
   input  logic                        flush,
   synchronous_fifo_reader_if.master   stream,
   output logic [1:0]                  occupancy,
   output logic [COUNT_WIDTH-1:0]      words_read
);

   logic [DATA_WIDTH-1:0] slot0;
   logic [DATA_WIDTH-1:0] slot1;
   logic [DATA_WIDTH-1:0] slot0_next;
   logic [DATA_WIDTH-1:0] slot1_next;
   logic                  pop;
   logic                  consume;
   logic                  poll_next;
   logic [1:0]            occ_shift;
   logic [1:0]            occ_next;

   assign stream.out_valid = (occupancy != 2'd0);
   assign stream.out_data  = slot0;

   always_comb begin
      pop        = fifo_poll && !fifo_empty;
      consume    = (occupancy != 2'd0) && stream.out_ready;
      occ_shift  = occupancy - {1'b0, consume};
      occ_next   = occ_shift + {1'b0, pop};
      slot0_next = slot0;
      slot1_next = slot1;

      // Only shift when slot1 really holds a word, so out_data keeps the
      // last delivered word once the buffer drains.
      if (consume && (occupancy == 2'd2)) begin
         slot0_next = slot1;
      end

      if (pop) begin
         if (occ_shift == 2'd0) begin
            slot0_next = fifo_head;
         end else begin
            slot1_next = fifo_head;
         end
      end

      // Discarded words never reach the slots; out_data simply holds.
      if (flush) begin
         occ_next   = 2'd0;
         slot0_next = slot0;
         slot1_next = slot1;
      end

      poll_next = !flush && (occ_next <= 2'd1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_poll  <= 1'b0;
         occupancy  <= 2'd0;
         slot0      <= '0;
         slot1      <= '0;
         words_read <= '0;
      end else begin
         fifo_poll <= poll_next;
         occupancy <= occ_next;
         slot0     <= slot0_next;
         slot1     <= slot1_next;
         if (consume) begin
            words_read <= words_read + COUNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_synchronous_fifo_reader.sv
// tb/tb_synchronous_fifo_reader.sv - scoreboard bench for synchronous_fifo_reader
// Queue-based FIFO and buffer model; directed scenarios followed by random traffic.
module tb_synchronous_fifo_reader;
   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] fifo_head = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_poll;
   logic          flush = 1'b0;
   logic [1:0]    occupancy;
   logic [CW-1:0] words_read;

   synchronous_fifo_reader_if #(.DATA_WIDTH(DW)) sif ();

   synchronous_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_head  (fifo_head),
      .fifo_empty (fifo_empty),
      .fifo_poll  (fifo_poll),
      .flush      (flush),
      .stream     (sif),
      .occupancy  (occupancy),
      .words_read (words_read)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_err = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [CW-1:0] exp_wr = '0;
   logic          exp_poll = 1'b1;
   logic          pop_now = 1'b0;
   logic [DW-1:0] popped_word = '0;
   int            rdy_mode = 0;
   logic          rnd_fill = 1'b0;
   logic          rnd_flush = 1'b0;
   logic          flush_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Stimulus: FIFO model and consumer, driven 1 time unit after each rising edge.
   initial begin
      sif.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0)      sif.out_ready = 1'b0;
         else if (rdy_mode == 1) sif.out_ready = 1'b1;
         else                    sif.out_ready = 1'($urandom_range(0, 1));
         flush     = flush_req || (rnd_flush && ($urandom_range(0, 19) == 0));
         flush_req = 1'b0;
         if (rnd_fill && ($urandom_range(0, 3) != 0) && (fifo_q.size() < 8))
            fifo_q.push_back(DW'($urandom));
         if (fifo_q.size() != 0) begin
            fifo_empty = 1'b0;
            fifo_head  = fifo_q[0];
         end else begin
            fifo_empty = 1'b1;
            fifo_head  = DW'($urandom);
         end
         pop_now = rst && fifo_poll && !fifo_empty;
         if (pop_now) begin
            popped_word = fifo_q.pop_front();
            exp_q.push_back(popped_word);
         end
      end
   end

   // Monitor: compares the DUT against the buffer model every falling edge.
   initial begin
      int occ;
      forever begin
         @(negedge clk);
         if (rst) begin
            occ = exp_q.size() - (pop_now ? 1 : 0);
            check("occupancy", 32'(occupancy), 32'(occ));
            check("out_valid", 32'(sif.out_valid), 32'(occ != 0));
            check("fifo_poll", 32'(fifo_poll), 32'(exp_poll));
            check("words_read", 32'(words_read), 32'(exp_wr));
            check("no_overflow", 32'(!(fifo_poll && occupancy == 2'd2) && occupancy <= 2'd2), 32'd1);
            if (occ > 0) begin
               check("out_data", 32'(sif.out_data), 32'(exp_q[0]));
               if (sif.out_ready) begin
                  void'(exp_q.pop_front());
                  exp_wr = exp_wr + CW'(1);
               end
            end
            if (flush) exp_q.delete();
            exp_poll = !flush && (exp_q.size() <= 1);
         end
      end
   end

   task automatic expect_word(input string name, input logic [DW-1:0] w, output int waited);
      waited = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         #1;
         if (sif.out_valid && sif.out_ready) begin
            waited = i;
            break;
         end
      end
      check({name, "_seen"}, 32'(waited != 0), 32'd1);
      if (waited != 0) check(name, 32'(sif.out_data), 32'(w));
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rst_poll", 32'(fifo_poll), 32'd0);
      check("rst_valid", 32'(sif.out_valid), 32'd0);
      check("rst_data", 32'(sif.out_data), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_words", 32'(words_read), 32'd0);
      // The pop planned for the aborted edge never happened; the FIFO keeps that word.
      if (pop_now) fifo_q.push_front(popped_word);
      pop_now  = 1'b0;
      exp_q.delete();
      exp_wr   = '0;
      exp_poll = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int            waited;
      logic [DW-1:0] resume_word;
      bit            found;

      repeat (2) @(negedge clk);
      #1;
      check("init_poll", 32'(fifo_poll), 32'd0);
      check("init_valid", 32'(sif.out_valid), 32'd0);
      check("init_data", 32'(sif.out_data), 32'd0);
      check("init_occ", 32'(occupancy), 32'd0);
      check("init_words", 32'(words_read), 32'd0);
      exp_poll = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("idle_poll", 32'(fifo_poll), 32'd1);
      check("idle_occ", 32'(occupancy), 32'd0);
      check("idle_valid", 32'(sif.out_valid), 32'd0);

      // Streaming with the consumer always ready.
      rdy_mode = 1;
      fifo_q.push_back(8'h11);
      fifo_q.push_back(8'h22);
      fifo_q.push_back(8'h33);
      expect_word("stream_w0", 8'h11, waited);
      expect_word("stream_w1", 8'h22, waited);
      check("stream_gap1", 32'(waited), 32'd1);
      expect_word("stream_w2", 8'h33, waited);
      check("stream_gap2", 32'(waited), 32'd1);
      @(negedge clk);
      #1;
      check("stream_valid_end", 32'(sif.out_valid), 32'd0);
      check("stream_words", 32'(words_read), 32'd3);

      // Backpressure: only two words may leave the FIFO.
      rdy_mode = 0;
      for (int k = 0; k < 4; k++) fifo_q.push_back(8'hA0 + 8'(k));
      repeat (6) @(negedge clk);
      #1;
      check("bp_occ", 32'(occupancy), 32'd2);
      check("bp_poll", 32'(fifo_poll), 32'd0);
      check("bp_fifo_left", 32'(fifo_q.size()), 32'd2);
      rdy_mode = 1;
      for (int k = 0; k < 4; k++) expect_word("bp_word", 8'hA0 + 8'(k), waited);
      @(negedge clk);
      #1;
      check("bp_words", 32'(words_read), 32'd7);

      // Flush with a full buffer and no consumer.
      rdy_mode = 0;
      fifo_q.push_back(8'hB0);
      fifo_q.push_back(8'hB1);
      repeat (5) @(negedge clk);
      #1;
      check("fl_occ_before", 32'(occupancy), 32'd2);
      flush_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("fl_occ", 32'(occupancy), 32'd0);
      check("fl_valid", 32'(sif.out_valid), 32'd0);
      check("fl_poll", 32'(fifo_poll), 32'd0);
      check("fl_words", 32'(words_read), 32'd7);
      @(negedge clk);
      #1;
      check("fl_poll_back", 32'(fifo_poll), 32'd1);

      // Asynchronous reset in the middle of a burst.
      rdy_mode = 1;
      for (int k = 0; k < 8; k++) fifo_q.push_back(8'hC0 + 8'(k));
      expect_word("mid_first", 8'hC0, waited);
      async_reset();
      resume_word = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      check("mid_fifo_left", 32'(fifo_q.size() != 0), 32'd1);
      expect_word("mid_resume", resume_word, waited);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (fifo_q.size() == 0 && !sif.out_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("mid_drained", 32'(found), 32'd1);

      // Counter wrap with a 4-bit counter.
      async_reset();
      for (int k = 1; k <= 17; k++) fifo_q.push_back(8'(k));
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (sif.out_valid && sif.out_data == 8'h10) begin
            found = 1'b1;
            break;
         end
      end
      check("wrap_seen16", 32'(found), 32'd1);
      check("wrap_words15", 32'(words_read), 32'd15);
      @(negedge clk);
      #1;
      check("wrap_words0", 32'(words_read), 32'd0);
      check("wrap_data17", 32'(sif.out_data), 32'h11);
      @(negedge clk);
      #1;
      check("wrap_words1", 32'(words_read), 32'd1);
      check("wrap_valid_end", 32'(sif.out_valid), 32'd0);

      // Random traffic, consumer stalls and flushes.
      rdy_mode  = 2;
      rnd_fill  = 1'b1;
      rnd_flush = 1'b1;
      repeat (3000) @(negedge clk);
      rnd_fill  = 1'b0;
      rnd_flush = 1'b0;
      rdy_mode  = 1;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (fifo_q.size() == 0 && !sif.out_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("rand_drained", 32'(found), 32'd1);
      check("rand_occ_end", 32'(occupancy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
